nco_tune_ctrl: RTL and testbench
================================

# nco_tune_ctrl

Tuning controller that owns the `phase_increment` word of the NCO and sequences frequency changes. A new target increment is accepted on a valid/ready config port. The block then either jumps to it in one cycle or slews toward it in fixed steps at a programmable interval. This avoids abrupt frequency hops at the mixer/LO. It sits between the control/register side and the NCO instance, and is the only driver of the NCO's `phase_increment` input.

## Interface
- `REGISTER_WIDTH`, default 64: width of the phase increment, target and step words; must match the NCO.
- `INTERVAL_WIDTH`, default 16: width of the slew interval counter.

Ports:
- `clk`  in  1: single clock for the whole block.
- `rst_n`  in  1: reset, synchronous and active-low.
- `cfg_valid`  in  1: config request valid.
- `cfg_ready`  out  1: controller can accept a request; high exactly when in IDLE and `rst_n`=1.
- `cfg_target`  in  REGISTER_WIDTH: target phase increment, unsigned.
- `cfg_step`  in  REGISTER_WIDTH: slew magnitude per update, unsigned; 0 = immediate jump.
- `cfg_interval`  in  INTERVAL_WIDTH: idle cycles between slew updates.
- `abort`  in  1: stop an in-progress slew and hold the current value.
- `phase_increment`  out  REGISTER_WIDTH: registered output that drives the NCO.
- `busy`  out  1: registered; high while in RAMP.
- `done`  out  1: registered one-cycle pulse when `phase_increment` reaches the target.

## Operation
- Reset (`rst_n`=0 at a `clk` edge):
  - `phase_increment`=0, state=IDLE, `busy`=0, `done`=0, internal counter=0.
  - `cfg_ready`=0 while `rst_n` is low.
- States: IDLE and RAMP.
- IDLE:
  - A request is accepted at an edge where `cfg_valid`=1 and `cfg_ready`=1.
  - On accept, latch `cfg_target`, `cfg_step` and `cfg_interval`.
  - If `cfg_step`=0 or `cfg_target`==`phase_increment`:
    - `phase_increment`<=target and `done`<=1.
    - Stay in IDLE, so back-to-back accepts are allowed.
  - Otherwise:
    - Latch direction: up if target>current, else down.
    - counter<=`cfg_interval`; state<=RAMP; `busy`<=1.
- RAMP, evaluated every edge:
  - If `abort`=1: state<=IDLE, `busy`<=0, `phase_increment` held, no `done`. Abort has priority over a coincident step.
  - Else if counter≠0: counter<=counter−1.
  - Else (counter==0), compute dist=|target−current| as an unsigned subtraction in the latched direction.
    - If dist<=step: `phase_increment`<=target, `done`<=1, state<=IDLE, `busy`<=0.
    - Else: `phase_increment`<=current±step and counter<=latched interval.
- Arithmetic:
  - Unsigned, REGISTER_WIDTH bits.
  - Overflow and underflow are impossible by construction: the block never overshoots and never wraps, because the dist comparison gates the final step.
- Requests while busy: `cfg_ready`=0, so `cfg_valid` is ignored and nothing is latched. The requester must hold its request until ready.
- `abort` in IDLE has no effect.
- `done`: deasserted on every edge where no completion occurs.

## Timing
- Accept at edge k, jump case:
  - `phase_increment` changes at edge k, visible from the cycle after k.
  - `done` is high for the single cycle following edge k.
- Accept at edge k, slew case:
  - The first update occurs at edge k+interval+1.
  - Subsequent updates are spaced interval+1 edges apart.
  - The final update (to the exact target) asserts `done` and deasserts `busy` at the same edge.
- Total slew updates = ceil(|target−start| / step).
- `cfg_ready` is combinational from state and `rst_n`; there is no combinational path from `cfg_valid` to `cfg_ready`.
- Reset mid-RAMP:
  - The next edge with `rst_n`=0 forces all reset values.
  - No `done` pulse; the latched request is discarded.

## Test plan
- Reset, then jump: after reset `phase_increment`=0 and `cfg_ready`=1. Accept target=1000, step=0 at edge k → `phase_increment`=1000 after k, `done` pulse for 1 cycle, `busy` stays 0, `cfg_ready` stays 1.
- Up-slew: start 0; target=100, step=30, interval=2, accepted at edge 0.
  - Values 30/60/90/100 appear at edges 3/6/9/12.
  - `done` at edge 12; `busy` high from edge 0 through edge 12.
- Down-slew with boundary: start 100; target=40, step=25, interval=0, accepted at edge 0.
  - Values 75/50/40 at edges 1/2/3; `done` at edge 3; no undershoot below 40.
- Top-of-range: start 2^W−10; target=2^W−1, step=4, interval=0.
  - Sequence 2^W−6, 2^W−2, 2^W−1, then `done`; never wraps to 0.
- Abort and busy blocking:
  - During the up-slew of the up-slew scenario, assert `cfg_valid` (target=5) at edge 4 → ignored.
  - Assert `abort` at edge 7 → `phase_increment` holds 60, `busy`=0, no `done`, `cfg_ready`=1 the next cycle.
- Reset mid-RAMP: drive `rst_n`=0 at edge 5 of the up-slew → `phase_increment`=0, `busy`=0, `done`=0. After release, a new request is accepted normally.

Source files
------------

// File: rtl/nco_tune_ctrl_if.sv
// Config request bus for nco_tune_ctrl: a new target/step/interval is offered with a valid/ready handshake.
interface nco_tune_ctrl_if #(
    parameter int REGISTER_WIDTH = 64,
    parameter int INTERVAL_WIDTH = 16
);
    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [REGISTER_WIDTH-1:0] cfg_target;
    logic [REGISTER_WIDTH-1:0] cfg_step;
    logic [INTERVAL_WIDTH-1:0] cfg_interval;

    modport master (
        output cfg_valid,
        output cfg_target,
        output cfg_step,
        output cfg_interval,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_target,
        input  cfg_step,
        input  cfg_interval,
        output cfg_ready
    );
endinterface

// File: rtl/nco_tune_ctrl.sv
// NCO tuning controller: owns phase_increment and either jumps to a requested target or
// slews toward it in fixed steps, never overshooting, so the LO does not hop abruptly.
module nco_tune_ctrl #(
    parameter int REGISTER_WIDTH = 64,
    parameter int INTERVAL_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    nco_tune_ctrl_if.slave            cfg,
    input  logic                      abort,
    output logic [REGISTER_WIDTH-1:0] phase_increment,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    state_t                    state_r,    state_s;
    logic [REGISTER_WIDTH-1:0] phase_r,    phase_s;
    logic [REGISTER_WIDTH-1:0] target_r,   target_s;
    logic [REGISTER_WIDTH-1:0] step_r,     step_s;
    logic [INTERVAL_WIDTH-1:0] interval_r, interval_s;
    logic [INTERVAL_WIDTH-1:0] counter_r,  counter_s;
    logic                      dir_up_r,   dir_up_s;
    logic                      busy_r,     busy_s;
    logic                      done_r,     done_s;
    logic [REGISTER_WIDTH-1:0] dist_s;

    // Ready depends only on state and reset, never on cfg_valid.
    assign cfg.cfg_ready   = rst_n && (state_r == ST_IDLE);
    assign phase_increment = phase_r;
    assign busy            = busy_r;
    assign done            = done_r;

    // Next-state and datapath decisions for the IDLE/RAMP sequencer.
    always_comb begin
        state_s    = state_r;
        phase_s    = phase_r;
        target_s   = target_r;
        step_s     = step_r;
        interval_s = interval_r;
        counter_s  = counter_r;
        dir_up_s   = dir_up_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        dist_s     = {REGISTER_WIDTH{1'b0}};

        case (state_r)
            ST_IDLE: begin
                if (cfg.cfg_valid) begin
                    target_s   = cfg.cfg_target;
                    step_s     = cfg.cfg_step;
                    interval_s = cfg.cfg_interval;
                    if ((cfg.cfg_step == {REGISTER_WIDTH{1'b0}}) || (cfg.cfg_target == phase_r)) begin
                        phase_s = cfg.cfg_target;
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                    end else begin
                        dir_up_s  = (cfg.cfg_target > phase_r);
                        counter_s = cfg.cfg_interval;
                        state_s   = ST_RAMP;
                        busy_s    = 1'b1;
                    end
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_RAMP: begin
                if (abort) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end else if (counter_r != {INTERVAL_WIDTH{1'b0}}) begin
                    counter_s = counter_r - {{(INTERVAL_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    // Direction is latched, so this subtraction never wraps.
                    if (dir_up_r) begin
                        dist_s = target_r - phase_r;
                    end else begin
                        dist_s = phase_r - target_r;
                    end
                    if (dist_s <= step_r) begin
                        phase_s = target_r;
                        done_s  = 1'b1;
                        state_s = ST_IDLE;
                        busy_s  = 1'b0;
                    end else begin
                        if (dir_up_r) begin
                            phase_s = phase_r + step_r;
                        end else begin
                            phase_s = phase_r - step_r;
                        end
                        counter_s = interval_r;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            phase_r    <= {REGISTER_WIDTH{1'b0}};
            target_r   <= {REGISTER_WIDTH{1'b0}};
            step_r     <= {REGISTER_WIDTH{1'b0}};
            interval_r <= {INTERVAL_WIDTH{1'b0}};
            counter_r  <= {INTERVAL_WIDTH{1'b0}};
            dir_up_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            phase_r    <= phase_s;
            target_r   <= target_s;
            step_r     <= step_s;
            interval_r <= interval_s;
            counter_r  <= counter_s;
            dir_up_r   <= dir_up_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

endmodule

// File: tb/tb_nco_tune_ctrl.sv
// Scoreboard bench for nco_tune_ctrl: directed requests push expected output events,
// a negedge monitor pops and compares every phase_increment change or done pulse.
module tb_nco_tune_ctrl;

    localparam int RW = 64;
    localparam int IW = 16;
    localparam logic [RW-1:0] MAX_INC = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        int          cyc;
        logic [RW-1:0] phase;
        logic        done;
        logic        busy;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          abort;
    logic [RW-1:0] phase_increment;
    logic          busy;
    logic          done;

    nco_tune_ctrl_if #(.REGISTER_WIDTH(RW), .INTERVAL_WIDTH(IW)) cfg_bus ();

    nco_tune_ctrl #(.REGISTER_WIDTH(RW), .INTERVAL_WIDTH(IW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg             (cfg_bus),
        .abort           (abort),
        .phase_increment (phase_increment),
        .busy            (busy),
        .done            (done)
    );

    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    bit            mon_en = 1'b0;
    logic [RW-1:0] last_phase = '0;
    exp_t          sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc equals the index of the preceding posedge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int c, input logic [RW-1:0] p, input logic d, input logic b);
        exp_t e;
        e.cyc = c; e.phase = p; e.done = d; e.busy = b;
        sb_q.push_back(e);
    endtask

    // Monitor: every visible output event must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && ((phase_increment !== last_phase) || (done === 1'b1))) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: phase %0d done %0b at edge %0d, none expected",
                         phase_increment, done, cyc);
            end else begin
                e = sb_q.pop_front();
                check("event_edge", RW'(cyc), RW'(e.cyc));
                check("event_phase", phase_increment, e.phase);
                check("event_done", {63'd0, done}, {63'd0, e.done});
                check("event_busy", {63'd0, busy}, {63'd0, e.busy});
            end
        end
        last_phase = phase_increment;
    end

    // Called at a negedge; returns there once the edge before edge e is next.
    task automatic goto_edge(input int e);
        while (cyc < e - 1) @(negedge clk);
    endtask

    task automatic issue(input logic [RW-1:0] tgt, input logic [RW-1:0] stp,
                         input logic [IW-1:0] ivl, output int k);
        int t;
        cfg_bus.cfg_valid    = 1'b1;
        cfg_bus.cfg_target   = tgt;
        cfg_bus.cfg_step     = stp;
        cfg_bus.cfg_interval = ivl;
        t = 0;
        while (cfg_bus.cfg_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: cfg_ready stayed %0b, required 1", cfg_bus.cfg_ready);
        end
        k = cyc + 1;
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({name, "_drained"}, RW'(sb_q.size()), RW'(0));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int k2;
        rst_n                = 1'b0;
        abort                = 1'b0;
        cfg_bus.cfg_valid    = 1'b0;
        cfg_bus.cfg_target   = '0;
        cfg_bus.cfg_step     = '0;
        cfg_bus.cfg_interval = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_phase", phase_increment, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_ready_low", {63'd0, cfg_bus.cfg_ready}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {63'd0, cfg_bus.cfg_ready}, 64'd1);
        mon_en = 1'b1;

        // Immediate jump
        issue(64'd1000, 64'd0, 16'd0, k);
        push_exp(k, 64'd1000, 1'b1, 1'b0);
        check("jump_busy", {63'd0, busy}, 64'd0);
        check("jump_ready", {63'd0, cfg_bus.cfg_ready}, 64'd1);
        drain("jump");

        // Up-slew with a blocked request in the middle
        issue(64'd0, 64'd0, 16'd0, k);
        push_exp(k, 64'd0, 1'b1, 1'b0);
        drain("zero");
        issue(64'd100, 64'd30, 16'd2, k);
        push_exp(k + 3, 64'd30, 1'b0, 1'b1);
        push_exp(k + 6, 64'd60, 1'b0, 1'b1);
        push_exp(k + 9, 64'd90, 1'b0, 1'b1);
        push_exp(k + 12, 64'd100, 1'b1, 1'b0);
        check("up_busy_start", {63'd0, busy}, 64'd1);
        goto_edge(k + 4);
        cfg_bus.cfg_valid  = 1'b1;
        cfg_bus.cfg_target = 64'd5;
        cfg_bus.cfg_step   = 64'd0;
        @(negedge clk);
        check("busy_ready_low", {63'd0, cfg_bus.cfg_ready}, 64'd0);
        goto_edge(k + 6);
        cfg_bus.cfg_valid = 1'b0;
        goto_edge(k + 12);
        check("up_busy_before_final", {63'd0, busy}, 64'd1);
        drain("up");

        // Down-slew ending exactly on target
        issue(64'd40, 64'd25, 16'd0, k);
        push_exp(k + 1, 64'd75, 1'b0, 1'b1);
        push_exp(k + 2, 64'd50, 1'b0, 1'b1);
        push_exp(k + 3, 64'd40, 1'b1, 1'b0);
        drain("down");
        check("down_no_undershoot", phase_increment, 64'd40);

        // Top of range: must stop at all-ones, never wrap
        issue(MAX_INC - 64'd9, 64'd0, 16'd0, k);
        push_exp(k, MAX_INC - 64'd9, 1'b1, 1'b0);
        drain("top_jump");
        issue(MAX_INC, 64'd4, 16'd0, k);
        push_exp(k + 1, MAX_INC - 64'd5, 1'b0, 1'b1);
        push_exp(k + 2, MAX_INC - 64'd1, 1'b0, 1'b1);
        push_exp(k + 3, MAX_INC, 1'b1, 1'b0);
        drain("top");
        check("top_no_wrap", phase_increment, MAX_INC);

        // Abort mid-slew holds the current value
        issue(64'd0, 64'd0, 16'd0, k);
        push_exp(k, 64'd0, 1'b1, 1'b0);
        drain("zero2");
        issue(64'd100, 64'd30, 16'd2, k);
        push_exp(k + 3, 64'd30, 1'b0, 1'b1);
        push_exp(k + 6, 64'd60, 1'b0, 1'b1);
        goto_edge(k + 7);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_phase", phase_increment, 64'd60);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_ready", {63'd0, cfg_bus.cfg_ready}, 64'd1);
        repeat (8) @(negedge clk);
        drain("abort");

        // Reset in the middle of a slew, then a normal request with abort held in IDLE
        issue(64'd0, 64'd0, 16'd0, k);
        push_exp(k, 64'd0, 1'b1, 1'b0);
        drain("zero3");
        issue(64'd100, 64'd30, 16'd2, k);
        push_exp(k + 3, 64'd30, 1'b0, 1'b1);
        push_exp(k + 5, 64'd0, 1'b0, 1'b0);
        goto_edge(k + 5);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_busy", {63'd0, busy}, 64'd0);
        check("midreset_done", {63'd0, done}, 64'd0);
        check("midreset_ready", {63'd0, cfg_bus.cfg_ready}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        abort = 1'b1;
        issue(64'd7, 64'd0, 16'd0, k2);
        abort = 1'b0;
        push_exp(k2, 64'd7, 1'b1, 1'b0);
        check("post_reset_busy", {63'd0, busy}, 64'd0);
        drain("post_reset");
        check("final_phase", phase_increment, 64'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
